// File: rtl/pq_pkg.sv
// Shared definitions for the priority-queue front-end.
//   cmd_e       : the single command issued to the queue each cycle
//   cmd_to_bits : maps a command onto the queue's {i_wrt, i_read} pins
package pq_pkg;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_WRT,
    CMD_READ,
    CMD_REPLACE
  } cmd_e;

  function automatic logic [1:0] cmd_to_bits(input cmd_e cmd);
    logic [1:0] bits;
    case (cmd)
      CMD_WRT:     bits = 2'b10;
      CMD_READ:    bits = 2'b01;
      CMD_REPLACE: bits = 2'b11;
      default:     bits = 2'b00;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/pq_enq_fifo.sv
// Enqueue buffer: synchronous FIFO with first-word-fall-through head.
// Ports:
//   i_CLK, i_RSTn : clock, asynchronous active-low reset
//   push, push_data : write one entry (caller guarantees !full)
//   pop             : drop the head entry (caller guarantees count != 0)
//   head            : oldest entry, valid whenever count != 0
//   full            : count == DEPTH
//   count           : number of stored entries, 0..DEPTH
module pq_enq_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                      i_CLK,
  input  logic                      i_RSTn,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     head,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it was written, and leaving it unreset lets it map onto plain flops/RAM.
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign full = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/pq_front_end.sv
// Command front-end for the register-array priority queue (largest at head,
// zero reserved as the empty-slot sentinel).
// Ports:
//   i_CLK, i_RSTn                  : clock, asynchronous active-low reset
//   i_enq_valid/o_enq_ready/i_enq_data : enqueue stream (zero values dropped)
//   i_deq_valid/o_deq_ready        : dequeue request stream
//   o_res_valid/i_res_ready/o_res_data : dequeued head results
//   o_pq_wrt/o_pq_read/o_pq_data   : one command per cycle to the queue
//   i_pq_full/i_pq_empty/i_pq_head : queue status and head value
//   o_drop_cnt                     : saturating count of dropped zero enqueues
//   o_idle                         : nothing buffered, pending or held
module pq_front_end
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ENQ_FIFO_DEPTH = 4,
  parameter int PQ_ENQ_ENA     = 0,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      i_CLK,
  input  logic                      i_RSTn,
  input  logic                      i_enq_valid,
  output logic                      o_enq_ready,
  input  logic [DATA_WIDTH-1:0]     i_enq_data,
  input  logic                      i_deq_valid,
  output logic                      o_deq_ready,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [DATA_WIDTH-1:0]     o_res_data,
  output logic                      o_pq_wrt,
  output logic                      o_pq_read,
  output logic [DATA_WIDTH-1:0]     o_pq_data,
  input  logic                      i_pq_full,
  input  logic                      i_pq_empty,
  input  logic [DATA_WIDTH-1:0]     i_pq_head,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt,
  output logic                      o_idle
);

  logic                              fifo_full;
  logic [$clog2(ENQ_FIFO_DEPTH):0]   fifo_count;
  logic [DATA_WIDTH-1:0]             fifo_head;
  logic                              fifo_nonempty;
  logic                              enq_hs;
  logic                              deq_hs;
  logic                              push;
  logic                              pending;
  logic                              deq_elig;
  cmd_e                              cmd;

  assign fifo_nonempty = (fifo_count != '0);
  assign o_enq_ready   = !fifo_full;
  assign o_deq_ready   = !pending;
  assign enq_hs        = i_enq_valid && o_enq_ready;
  assign deq_hs        = i_deq_valid && o_deq_ready;
  // Zero is the queue's empty-slot sentinel, so it is accepted but never stored.
  assign push          = enq_hs && (i_enq_data != '0);

  // A dequeue may issue only if the queue has something and the result
  // register is free or being drained this cycle.
  assign deq_elig = pending && !i_pq_empty && (!o_res_valid || i_res_ready);

  pq_enq_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (ENQ_FIFO_DEPTH)
  ) u_enq_fifo (
    .i_CLK     (i_CLK),
    .i_RSTn    (i_RSTn),
    .push      (push),
    .push_data (i_enq_data),
    .pop       (o_pq_wrt),
    .head      (fifo_head),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    cmd = CMD_NONE;
    if (deq_elig && fifo_nonempty) begin
      cmd = CMD_REPLACE;
    end else if (deq_elig) begin
      cmd = CMD_READ;
    end else if (fifo_nonempty) begin
      // On an empty queue a replace acts as a plain insert (returned head is 0
      // and ignored); otherwise a bare write is only legal if the queue
      // accepts writes and has room, else the entry waits for a dequeue.
      if (i_pq_empty) begin
        cmd = CMD_REPLACE;
      end else if (!i_pq_full && (PQ_ENQ_ENA != 0)) begin
        cmd = CMD_WRT;
      end
    end
  end

  assign {o_pq_wrt, o_pq_read} = cmd_to_bits(cmd);
  assign o_pq_data             = o_pq_wrt ? fifo_head : '0;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      pending     <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_drop_cnt  <= '0;
    end else begin
      // deq_hs needs !pending and deq_elig needs pending: never both.
      if (deq_elig)    pending <= 1'b0;
      else if (deq_hs) pending <= 1'b1;

      // Reload wins over drain, giving back-to-back results.
      if (deq_elig) begin
        o_res_valid <= 1'b1;
        o_res_data  <= i_pq_head;
      end else if (i_res_ready) begin
        o_res_valid <= 1'b0;
      end

      if (enq_hs && (i_enq_data == '0) && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

  assign o_idle = !fifo_nonempty && !pending && !o_res_valid;

endmodule

// File: tb/tb_pq_front_end.sv
// Directed self-checking bench for pq_front_end. The bench plays the role of
// the downstream queue by driving i_pq_full/i_pq_empty/i_pq_head by hand.
module tb_pq_front_end;

  localparam int DW  = 16;
  localparam int DCW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enq_valid;
  logic          enq_ready;
  logic [DW-1:0] enq_data;
  logic          deq_valid;
  logic          deq_ready;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          pq_wrt;
  logic          pq_read;
  logic [DW-1:0] pq_data;
  logic          pq_full;
  logic          pq_empty;
  logic [DW-1:0] pq_head;
  logic [DCW-1:0] drop_cnt;
  logic          idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pq_front_end #(
    .DATA_WIDTH     (DW),
    .ENQ_FIFO_DEPTH (4),
    .PQ_ENQ_ENA     (0),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .i_CLK       (clk),
    .i_RSTn      (rst_n),
    .i_enq_valid (enq_valid),
    .o_enq_ready (enq_ready),
    .i_enq_data  (enq_data),
    .i_deq_valid (deq_valid),
    .o_deq_ready (deq_ready),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_pq_wrt    (pq_wrt),
    .o_pq_read   (pq_read),
    .o_pq_data   (pq_data),
    .i_pq_full   (pq_full),
    .i_pq_empty  (pq_empty),
    .i_pq_head   (pq_head),
    .o_drop_cnt  (drop_cnt),
    .o_idle      (idle)
  );

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic check_cmd(input string tag, input logic wrt, input logic rd,
                           input logic [DW-1:0] data);
    check({tag, "_wrt"},  32'(pq_wrt),  32'(wrt));
    check({tag, "_read"}, 32'(pq_read), 32'(rd));
    check({tag, "_data"}, 32'(pq_data), 32'(data));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    check({tag, "_deq_ready"}, 32'(deq_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
    check({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
    check({tag, "_idle"},      32'(idle),      32'd1);
    check_cmd(tag, 1'b0, 1'b0, '0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled a
  // further time unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_valid = 1'b0;
    res_ready = 1'b1;
    pq_full   = 1'b0;
    pq_empty  = 1'b1;
    pq_head   = '0;

    #2;
    check_reset_values("rst");
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    check_reset_values("post_rst");

    // Enqueue 5 on an empty queue, then a dequeue request.
    enq_valid = 1'b1; enq_data = 16'h0005;
    settle();
    check_cmd("t1_idle_cmd", 1'b0, 1'b0, '0);
    tick();
    enq_valid = 1'b0; deq_valid = 1'b1;
    settle();
    check_cmd("t1_replace", 1'b1, 1'b1, 16'h0005);
    check("t1_deq_ready", 32'(deq_ready), 32'd1);
    tick();
    deq_valid = 1'b0; pq_empty = 1'b0; pq_head = 16'h0005;
    settle();
    check_cmd("t1_read", 1'b0, 1'b1, '0);
    check("t1_res_valid_early", 32'(res_valid), 32'd0);
    tick();
    pq_empty = 1'b1; pq_head = '0;
    settle();
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_data",  32'(res_data),  32'h0005);
    check_cmd("t1_quiet", 1'b0, 1'b0, '0);
    tick();
    settle();
    check("t1_res_drained", 32'(res_valid), 32'd0);
    check("t1_idle",        32'(idle),      32'd1);

    // Three zero enqueues are dropped and counted.
    enq_valid = 1'b1; enq_data = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t2_no_wrt", 32'(pq_wrt), 32'd0);
      check("t2_idle",   32'(idle),   32'd1);
      tick();
    end
    enq_valid = 1'b0;
    settle();
    check("t2_drop_cnt", 32'(drop_cnt), 32'd3);
    check("t2_idle_end", 32'(idle),     32'd1);
    check("t2_no_wrt_end", 32'(pq_wrt), 32'd0);

    // Queue holds 0x10; 0x20 waits (writes disabled) until a dequeue pairs.
    pq_empty = 1'b0; pq_head = 16'h0010;
    enq_valid = 1'b1; enq_data = 16'h0020;
    tick();
    enq_valid = 1'b0;
    settle();
    check_cmd("t3_wait0", 1'b0, 1'b0, '0);
    check("t3_not_idle", 32'(idle), 32'd0);
    tick();
    settle();
    check_cmd("t3_wait1", 1'b0, 1'b0, '0);
    deq_valid = 1'b1;
    tick();
    deq_valid = 1'b0;
    settle();
    check_cmd("t3_replace", 1'b1, 1'b1, 16'h0020);
    tick();
    pq_head = 16'h0020;
    settle();
    check("t3_res_valid", 32'(res_valid), 32'd1);
    check("t3_res_data",  32'(res_data),  32'h0010);
    check_cmd("t3_quiet", 1'b0, 1'b0, '0);
    tick();

    // Full queue: simultaneous enqueue 7 and dequeue give a replace.
    pq_full = 1'b1; pq_head = 16'h0030;
    enq_valid = 1'b1; enq_data = 16'h0007; deq_valid = 1'b1;
    tick();
    enq_valid = 1'b0; deq_valid = 1'b0;
    settle();
    check_cmd("t4_replace_full", 1'b1, 1'b1, 16'h0007);
    tick();
    pq_full = 1'b0; pq_head = 16'h0028;
    settle();
    check("t4_res_valid", 32'(res_valid), 32'd1);
    check("t4_res_data",  32'(res_data),  32'h0030);
    check_cmd("t4_quiet", 1'b0, 1'b0, '0);
    tick();

    // Result held with res_ready low stalls a second dequeue.
    res_ready = 1'b0; pq_head = 16'h0040;
    deq_valid = 1'b1;
    tick();
    deq_valid = 1'b0;
    settle();
    check_cmd("t5_read1", 1'b0, 1'b1, '0);
    tick();
    pq_head = 16'h0041;
    settle();
    check("t5_res_valid1", 32'(res_valid), 32'd1);
    check("t5_res_data1",  32'(res_data),  32'h0040);
    check("t5_deq_ready",  32'(deq_ready), 32'd1);
    deq_valid = 1'b1;
    tick();
    deq_valid = 1'b0;
    settle();
    check_cmd("t5_stall0", 1'b0, 1'b0, '0);
    check("t5_deq_busy", 32'(deq_ready), 32'd0);
    tick();
    settle();
    check_cmd("t5_stall1", 1'b0, 1'b0, '0);
    check("t5_res_held", 32'(res_data), 32'h0040);
    res_ready = 1'b1;
    settle();
    check_cmd("t5_read2", 1'b0, 1'b1, '0);
    tick();
    res_ready = 1'b0;
    settle();
    check("t5_res_valid2", 32'(res_valid), 32'd1);
    check("t5_res_data2",  32'(res_data),  32'h0041);

    // Fill the FIFO with a dequeue pending, then reset mid-operation.
    deq_valid = 1'b1; enq_valid = 1'b1; enq_data = 16'h0011;
    tick();
    deq_valid = 1'b0; enq_data = 16'h0012;
    tick();
    enq_data = 16'h0013;
    tick();
    enq_data = 16'h0014;
    tick();
    enq_valid = 1'b0;
    settle();
    check("t6_enq_ready_full", 32'(enq_ready), 32'd0);
    check("t6_deq_busy",       32'(deq_ready), 32'd0);
    check("t6_not_idle",       32'(idle),      32'd0);
    check_cmd("t6_hold", 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    settle();
    check_reset_values("t6_async_rst");
    pq_empty = 1'b1; pq_head = '0; res_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    check_reset_values("t6_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
